// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin arbiter sharing one Data_Memory line port between
//               two requesters, with one idle cycle after every ack.
// Rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // The last pointer starts opposite PRIO_INIT so PRIO_INIT wins the first tie.
  localparam logic c_LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;
  logic   arb_winner;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= c_LAST_INIT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    if (m0_enable_i && m1_enable_i) begin
      arb_winner = ~last_q;
    end else begin
      arb_winner = m1_enable_i;
    end
  end

  // Reset gates every output so a pending ack can never escape during reset.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    grant_o      = 2'b00;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (m0_enable_i || m1_enable_i) begin
            owner_d = arb_winner;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          mem_enable_o = 1'b1;
          mem_write_o  = owner_q ? m1_write_i : m0_write_i;
          mem_addr_o   = owner_q ? m1_addr_i  : m0_addr_i;
          mem_data_o   = owner_q ? m1_data_i  : m0_data_i;
          grant_o      = owner_q ? 2'b10 : 2'b01;
          if (mem_ack_i) begin
            m0_ack_o = ~owner_q;
            m1_ack_o = owner_q;
            last_d   = owner_q;
            state_d  = ST_GAP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : table vectors, directed multi-cycle sequences and a
//                  randomized requester/memory scoreboard for mem_arbiter.
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int AW     = 32;
  localparam int DW     = 256;
  localparam int LAT    = 10;
  localparam int NLINES = 64;
  localparam int NROWS  = 23;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          m0_enable_i = 1'b0, m0_write_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0;
  logic [DW-1:0] m0_data_i = '0;
  logic          m1_enable_i = 1'b0, m1_write_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic [DW-1:0] m1_data_i = '0;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_data_i = '0;
  logic          m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o;
  logic [DW-1:0] m0_data_o, m1_data_o, mem_data_o;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]    grant_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_INIT(0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant_o(grant_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic ok, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic       rst, e0, w0, e1, w1, ack;
    logic       x_en, x_wr;
    logic [1:0] x_gnt;
    logic       x_a0, x_a1;
    logic [1:0] x_sel;   // 0: no owner, 1: m0 drives memory, 2: m1 drives memory
  } vec_t;

  localparam logic [AW-1:0] T_A0 = 32'h0000_0100;
  localparam logic [AW-1:0] T_A1 = 32'h0000_0300;

  // ---------------- memory device and reference ----------------
  logic [DW-1:0] dev_mem [NLINES];
  logic [DW-1:0] ref_mem [NLINES];
  bit            auto_mem = 1'b0;
  int            mem_cnt  = 0;

  function automatic logic [DW-1:0] init_line(input int idx);
    logic [DW-1:0] l;
    logic [31:0]   base;
    base = 32'(idx) << 7;
    for (int k = 0; k < 8; k++) l[DW-1-32*k -: 32] = base + 32'(k + 1);
    return l;
  endfunction

  function automatic int line_of(input logic [AW-1:0] a);
    return int'(a[10:5]);
  endfunction

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic mem_step();
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (mem_enable_o) begin
      mem_cnt++;
      if (mem_cnt == LAT) begin
        mem_cnt   = 0;
        mem_ack_i = 1'b1;
        if (mem_write_o) dev_mem[line_of(mem_addr_o)] = mem_data_o;
        else             mem_data_i = dev_mem[line_of(mem_addr_o)];
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  // ---------------- requester engine and scoreboard ----------------
  typedef struct packed {
    logic          id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct packed {
    logic          id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [31:0]   cyc;
  } done_t;

  txn_t        pend[$];
  done_t       log_q[$];
  txn_t        cur [2];
  bit          busy [2];
  bit          acked [2];
  int          hold [2];
  int          foreign [2];
  bit          rand_hold = 1'b0;
  bit          auto_req  = 1'b0;
  bit          after_ack = 1'b0;
  int unsigned cyc = 0;

  function automatic txn_t mk_txn(input logic id, input logic wr, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] data);
    txn_t t;
    t.id = id; t.wr = wr; t.addr = addr; t.data = data;
    return t;
  endfunction

  task automatic req_step();
    for (int k = 0; k < 2; k++) begin
      if (busy[k] && acked[k]) begin
        busy[k]  = 1'b0;
        acked[k] = 1'b0;
        hold[k]  = rand_hold ? int'($urandom_range(0, 3)) : 0;
      end
      if (!busy[k]) begin
        if (hold[k] > 0) begin
          hold[k]--;
        end else begin
          for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].id == (k == 1)) begin
              cur[k]  = pend[i];
              busy[k] = 1'b1;
              pend.delete(i);
              break;
            end
          end
        end
      end
    end
    m0_enable_i = busy[0]; m0_write_i = cur[0].wr; m0_addr_i = cur[0].addr; m0_data_i = cur[0].data;
    m1_enable_i = busy[1]; m1_write_i = cur[1].wr; m1_addr_i = cur[1].addr; m1_data_i = cur[1].data;
  endtask

  task automatic observe();
    int            k;
    int            ln;
    logic [1:0]    g_exp;
    logic [DW-1:0] rd;
    done_t         d;
    if (after_ack) begin
      chk("gap_cycle", mem_enable_o == 1'b0 && grant_o == 2'b00,
          $sformatf("mem_enable_o=%0b grant_o=%b, required 0 and 00", mem_enable_o, grant_o));
      after_ack = 1'b0;
    end
    if (m0_ack_o || m1_ack_o) begin
      k         = m1_ack_o ? 1 : 0;
      after_ack = 1'b1;
      g_exp     = (k == 1) ? 2'b10 : 2'b01;
      rd        = (k == 1) ? m1_data_o : m0_data_o;
      chk("ack_owner", busy[k] && !(m0_ack_o && m1_ack_o) && grant_o == g_exp,
          $sformatf("acks=%0b%0b grant_o=%b requester%0d pending=%0b, required grant %b",
                    m1_ack_o, m0_ack_o, grant_o, k, busy[k], g_exp));
      chk("route", mem_addr_o == cur[k].addr && mem_write_o == cur[k].wr &&
                   (!cur[k].wr || mem_data_o == cur[k].data),
          $sformatf("addr=%h wr=%0b, required addr=%h wr=%0b", mem_addr_o, mem_write_o,
                    cur[k].addr, cur[k].wr));
      ln = line_of(cur[k].addr);
      if (cur[k].wr) ref_mem[ln] = cur[k].data;
      else chk("rdata", rd == ref_mem[ln],
               $sformatf("line %0d got %h required %h", ln, rd, ref_mem[ln]));
      chk("fairness", foreign[k] <= 1,
          $sformatf("requester%0d waited through %0d foreign transactions, required <=1", k, foreign[k]));
      foreign[k] = 0;
      if (busy[1-k]) foreign[1-k]++;
      d.id = (k == 1); d.wr = cur[k].wr; d.addr = cur[k].addr; d.rdata = rd; d.cyc = cyc;
      log_q.push_back(d);
      acked[k] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_mem) mem_step();
    if (auto_req) req_step();
    #1;
    if (auto_req) observe();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (log_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk(name, log_q.size() >= n,
        $sformatf("completions=%0d, required %0d within %0d cycles", log_q.size(), n, budget));
  endtask

  task automatic auto_reset();
    rst_i = 1'b1;
    pend.delete();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; acked[k] = 1'b0; hold[k] = 0; foreign[k] = 0;
    end
    mem_ack_i = 1'b0; mem_cnt = 0; after_ack = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    log_q.delete();
  endtask

  function automatic logic outputs_zero();
    return mem_enable_o == 1'b0 && mem_write_o == 1'b0 && mem_addr_o == '0 && mem_data_o == '0 &&
           m0_ack_o == 1'b0 && m1_ack_o == 1'b0 && grant_o == 2'b00;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t          tbl [NROWS];
    logic [AW-1:0] xa;
    logic [DW-1:0] xd, wb_data;
    logic [5:0]    got, exp;
    int unsigned   t_req;
    int            guard;

    //            rst e0 w0 e1 w1 ack   en wr  gnt   a0 a1  sel
    tbl[0]  = {6'b110100, 2'b00, 2'b00, 2'b00, 2'd0};   // reset with both requesting
    tbl[1]  = {6'b000000, 2'b00, 2'b00, 2'b00, 2'd0};   // idle
    tbl[2]  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'd0};   // stray ack in IDLE
    tbl[3]  = {6'b010100, 2'b00, 2'b00, 2'b00, 2'd0};   // tie seen in IDLE
    tbl[4]  = {6'b010100, 2'b10, 2'b01, 2'b00, 2'd1};   // m0 wins first tie
    tbl[5]  = {6'b010101, 2'b10, 2'b01, 2'b10, 2'd1};   // m0 ack
    tbl[6]  = {6'b010100, 2'b00, 2'b00, 2'b00, 2'd0};   // GAP, m0 re-requests
    tbl[7]  = {6'b010110, 2'b11, 2'b10, 2'b00, 2'd2};   // m1 wins round robin
    tbl[8]  = {6'b000111, 2'b11, 2'b10, 2'b01, 2'd2};   // m1 ack
    tbl[9]  = {6'b000110, 2'b00, 2'b00, 2'b00, 2'd0};   // GAP, m1 alone
    tbl[10] = {6'b000110, 2'b11, 2'b10, 2'b00, 2'd2};
    tbl[11] = {6'b000010, 2'b11, 2'b10, 2'b00, 2'd2};   // m1 drops enable mid-BUSY
    tbl[12] = {6'b000011, 2'b11, 2'b10, 2'b01, 2'd2};   // ack still forwarded
    tbl[13] = {6'b000000, 2'b00, 2'b00, 2'b00, 2'd0};   // GAP
    tbl[14] = {6'b000000, 2'b00, 2'b00, 2'b00, 2'd0};   // IDLE
    tbl[15] = {6'b000100, 2'b00, 2'b00, 2'b00, 2'd0};
    tbl[16] = {6'b100101, 2'b00, 2'b00, 2'b00, 2'd0};   // reset and ack together in BUSY
    tbl[17] = {6'b000100, 2'b00, 2'b00, 2'b00, 2'd0};   // back in IDLE
    tbl[18] = {6'b000100, 2'b10, 2'b10, 2'b00, 2'd2};
    tbl[19] = {6'b000101, 2'b10, 2'b10, 2'b01, 2'd2};
    tbl[20] = {6'b000001, 2'b00, 2'b00, 2'b00, 2'd0};   // stray ack in GAP
    tbl[21] = {6'b010100, 2'b00, 2'b00, 2'b00, 2'd0};
    tbl[22] = {6'b010100, 2'b10, 2'b01, 2'b00, 2'd1};   // tie after m1 served: m0

    m0_addr_i = T_A0; m0_data_i = {8{32'hA0A0_0000}};
    m1_addr_i = T_A1; m1_data_i = {8{32'h0B0B_1111}};
    for (int i = 0; i < NROWS; i++) begin
      @(posedge clk);
      #1;
      rst_i       = tbl[i].rst;
      m0_enable_i = tbl[i].e0; m0_write_i = tbl[i].w0;
      m1_enable_i = tbl[i].e1; m1_write_i = tbl[i].w1;
      mem_ack_i   = tbl[i].ack;
      mem_data_i  = rand256();
      #1;
      xa  = (tbl[i].x_sel == 2'd1) ? T_A0 : (tbl[i].x_sel == 2'd2) ? T_A1 : '0;
      xd  = (tbl[i].x_sel == 2'd1) ? m0_data_i : (tbl[i].x_sel == 2'd2) ? m1_data_i : '0;
      got = {mem_enable_o, mem_write_o, grant_o, m0_ack_o, m1_ack_o};
      exp = {tbl[i].x_en, tbl[i].x_wr, tbl[i].x_gnt, tbl[i].x_a0, tbl[i].x_a1};
      chk($sformatf("vector%0d", i),
          got == exp && mem_addr_o == xa && mem_data_o == xd &&
          m0_data_o == mem_data_i && m1_data_o == mem_data_i,
          $sformatf("{en,wr,gnt,a0,a1}=%b addr=%h, required %b addr=%h (data paths ok=%0b)",
                    got, mem_addr_o, exp, xa,
                    mem_data_o == xd && m0_data_o == mem_data_i && m1_data_o == mem_data_i));
    end

    for (int i = 0; i < NLINES; i++) begin
      dev_mem[i] = init_line(i);
      ref_mem[i] = init_line(i);
    end
    mem_ack_i = 1'b0;
    auto_mem  = 1'b1;
    auto_req  = 1'b1;

    // Single read from m0.
    auto_reset();
    pend.push_back(mk_txn(1'b0, 1'b0, 32'h0000_0020, '0));
    tick();
    t_req = cyc;
    tick();
    chk("single_start", mem_enable_o && !mem_write_o && mem_addr_o == 32'h20 && grant_o == 2'b01,
        $sformatf("en=%0b wr=%0b addr=%h grant=%b, required 1 0 00000020 01",
                  mem_enable_o, mem_write_o, mem_addr_o, grant_o));
    wait_log(1, 40, "single_done");
    if (log_q.size() >= 1)
      chk("single_result", log_q[0].id == 1'b0 && log_q[0].cyc == t_req + LAT &&
                           log_q[0].rdata == init_line(1),
          $sformatf("id=%0d ack_cycle=%0d, required id 0 at cycle %0d with line 1",
                    log_q[0].id, log_q[0].cyc, t_req + LAT));

    // Tie after reset: m0 first, exactly one gap cycle, then m1.
    auto_reset();
    pend.push_back(mk_txn(1'b0, 1'b0, 32'h0000_0060, '0));
    pend.push_back(mk_txn(1'b1, 1'b0, 32'h0000_0400, '0));
    wait_log(2, 60, "tie_done");
    if (log_q.size() >= 2)
      chk("tie_order", log_q[0].id == 1'b0 && log_q[1].id == 1'b1 &&
                       log_q[1].cyc - log_q[0].cyc == LAT + 1 &&
                       log_q[1].rdata[DW-1 -: 32] == 32'h0000_1001,
          $sformatf("ids=%0d,%0d spacing=%0d top_word=%h, required 0,1 spacing %0d top 00001001",
                    log_q[0].id, log_q[1].id, log_q[1].cyc - log_q[0].cyc,
                    log_q[1].rdata[DW-1 -: 32], LAT + 1));

    // Back-to-back fairness: m0 write-back then allocate while m1 waits.
    auto_reset();
    wb_data = rand256();
    pend.push_back(mk_txn(1'b0, 1'b1, 32'h0000_0200, wb_data));
    pend.push_back(mk_txn(1'b0, 1'b0, 32'h0000_0040, '0));
    pend.push_back(mk_txn(1'b1, 1'b0, 32'h0000_0000, '0));
    wait_log(3, 80, "b2b_done");
    if (log_q.size() >= 3)
      chk("b2b_order", log_q[0].id == 1'b0 && log_q[0].wr && log_q[0].addr == 32'h200 &&
                       log_q[1].id == 1'b1 && log_q[1].addr == 32'h0 &&
                       log_q[2].id == 1'b0 && log_q[2].addr == 32'h40,
          $sformatf("order ids=%0d,%0d,%0d addrs=%h,%h,%h, required 0,1,0 200,000,040",
                    log_q[0].id, log_q[1].id, log_q[2].id,
                    log_q[0].addr, log_q[1].addr, log_q[2].addr));
    chk("b2b_memory", dev_mem[line_of(32'h200)] == wb_data,
        $sformatf("line 0x200 holds %h, required %h", dev_mem[line_of(32'h200)], wb_data));

    // Reset five cycles into BUSY, then a fresh m1 request.
    auto_reset();
    pend.push_back(mk_txn(1'b0, 1'b0, 32'h0000_0080, '0));
    guard = 0;
    while (!mem_enable_o && guard < 5) begin
      tick();
      guard++;
    end
    chk("reset_busy_reached", mem_enable_o == 1'b1,
        $sformatf("mem_enable_o=%0b, required 1", mem_enable_o));
    repeat (4) tick();
    rst_i = 1'b1;
    busy[0] = 1'b0;
    m0_enable_i = 1'b0;
    tick();
    chk("reset_outputs", outputs_zero() && log_q.size() == 0,
        $sformatf("en=%0b grant=%b acks=%0b%0b completions=%0d, required all zero",
                  mem_enable_o, grant_o, m1_ack_o, m0_ack_o, log_q.size()));
    rst_i = 1'b0;
    tick();
    chk("reset_idle", outputs_zero(),
        $sformatf("en=%0b grant=%b, required 0 and 00", mem_enable_o, grant_o));
    pend.push_back(mk_txn(1'b1, 1'b0, 32'h0000_0400, '0));
    wait_log(1, 40, "reset_resume");
    if (log_q.size() >= 1)
      chk("reset_resume_data", log_q[0].id == 1'b1 && log_q[0].rdata == init_line(32),
          $sformatf("id=%0d top_word=%h, required id 1 top 00001001",
                    log_q[0].id, log_q[0].rdata[DW-1 -: 32]));

    // Randomized traffic checked by the scoreboard.
    auto_reset();
    rand_hold = 1'b1;
    for (int i = 0; i < 60; i++)
      pend.push_back(mk_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            {21'b0, 6'($urandom_range(0, NLINES - 1)), 5'b0}, rand256()));
    wait_log(60, 3000, "random_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
